// File: rtl/collision_scan_pkg.sv
// collision_scan_pkg
//   Shared constants and FSM encoding for the collision scanner.
//   BOARD_ROWS : playfield rows (0..BOARD_ROWS-1)
//   ROW_W      : bits per board/piece row
//   PIECE_ROWS : rows in a piece footprint
package collision_scan_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int ROW_W      = 32;
    localparam int PIECE_ROWS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/collision_scan_if.sv
// collision_scan_if
//   Request, result and board-memory signals of the collision scanner.
//   master : the requester / board memory side
//   slave  : the scanner itself
//   start, piece_mask, base_row : scan request
//   busy, done, collision, hit_row : status and result
//   board_rd_addr, board_rd_data : synchronous board memory read port
interface collision_scan_if
    import collision_scan_pkg::*;
#(
    parameter int W = ROW_W
);
    logic                     start;
    logic [PIECE_ROWS*W-1:0]  piece_mask;
    logic [4:0]               base_row;
    logic [4:0]               board_rd_addr;
    logic [W-1:0]             board_rd_data;
    logic                     busy;
    logic                     done;
    logic                     collision;
    logic [5:0]               hit_row;

    modport master (
        output start, piece_mask, base_row, board_rd_data,
        input  board_rd_addr, busy, done, collision, hit_row
    );

    modport slave (
        input  start, piece_mask, base_row, board_rd_data,
        output board_rd_addr, busy, done, collision, hit_row
    );
endinterface

// File: rtl/bitwise_and.sv
// bitwise_and
//   Plain W-bit bitwise AND.
//   a, b : operands
//   y    : a & b
module bitwise_and #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a & b;
endmodule

// File: rtl/collision_scan.sv
// collision_scan
//   Scans the four rows of a piece against the board, one row per
//   READ/CHECK pair, stopping at the first overlap. Rows at or beyond
//   BOARD_ROWS act as a solid floor.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : request/result/board-memory signals (slave side)
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for start; result outputs hold last scan
//   ST_READ  | board address for piece row idx presented to memory
//   ST_CHECK | board data back; test overlap, advance or finish
//   ST_DONE  | one-cycle done pulse
module collision_scan
    import collision_scan_pkg::*;
#(
    parameter int BOARD_ROWS = collision_scan_pkg::BOARD_ROWS,
    parameter int ROW_W      = collision_scan_pkg::ROW_W
) (
    input  logic             clock,
    input  logic             reset,
    collision_scan_if.slave  bus
);

    state_e                      state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [PIECE_ROWS*ROW_W-1:0] mask_q, mask_d;
    logic [4:0]                  base_q, base_d;
    logic                        collision_q, collision_d;
    logic [5:0]                  hit_row_q, hit_row_d;

    logic [5:0]                  row;
    logic                        row_in_range;
    logic [ROW_W-1:0]            piece_row;
    logic [ROW_W-1:0]            eff_board;
    logic [ROW_W-1:0]            overlap;
    logic                        hit;
    logic [4:0]                  rd_addr;

    // Six bits wide so base_row+idx past 31 never aliases onto the board.
    assign row          = {1'b0, base_q} + {4'b0, idx_q};
    assign row_in_range = (row < 6'(BOARD_ROWS));
    assign piece_row    = mask_q[ROW_W*int'(idx_q) +: ROW_W];
    assign eff_board    = row_in_range ? bus.board_rd_data : '1;

    bitwise_and #(.W(ROW_W)) u_and (
        .a (piece_row),
        .b (eff_board),
        .y (overlap)
    );

    assign hit = |overlap;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        base_d      = base_q;
        collision_d = collision_q;
        hit_row_d   = hit_row_q;
        rd_addr     = 5'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_d      = bus.piece_mask;
                    base_d      = bus.base_row;
                    idx_d       = 2'd0;
                    collision_d = 1'b0;
                    hit_row_d   = 6'd0;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                if (row_in_range) rd_addr = row[4:0];
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Address held so the memory port stays stable while data is consumed.
                if (row_in_range) rd_addr = row[4:0];
                if (hit) begin
                    collision_d = 1'b1;
                    hit_row_d   = row;
                    state_d     = ST_DONE;
                end else if (idx_q == 2'(PIECE_ROWS-1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            mask_q      <= '0;
            base_q      <= 5'd0;
            collision_q <= 1'b0;
            hit_row_q   <= 6'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            base_q      <= base_d;
            collision_q <= collision_d;
            hit_row_q   <= hit_row_d;
        end
    end

    assign bus.board_rd_addr = rd_addr;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.collision     = collision_q;
    assign bus.hit_row       = hit_row_q;

endmodule

// File: tb/tb_collision_scan.sv
// tb_collision_scan
//   Scoreboard bench for collision_scan: expected results are computed from
//   a board model when a scan is issued and compared when done pulses.
module tb_collision_scan;
    import collision_scan_pkg::*;

    typedef struct {
        logic       coll;
        logic [5:0] hit;
        int         lat;
        logic [4:0] base;
    } exp_t;

    exp_t sb_q[$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    collision_scan_if bus ();

    collision_scan dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] board_mem [0:31];
    always @(posedge clock) bus.board_rd_data <= board_mem[bus.board_rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pm(input logic [31:0] r0, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [31:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic exp_t model(input logic [127:0] mask, input logic [4:0] base);
        exp_t        e;
        int          row;
        logic [31:0] eff;
        logic        found;
        e.coll = 1'b0;
        e.hit  = 6'd0;
        e.lat  = 9;
        e.base = base;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            row = int'(base) + i;
            eff = (row < 20) ? board_mem[row] : 32'hFFFF_FFFF;
            if (!found && (|(mask[32*i +: 32] & eff))) begin
                found  = 1'b1;
                e.coll = 1'b1;
                e.hit  = 6'(row);
                e.lat  = 2*i + 3;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [127:0] mask, input logic [4:0] base);
        bus.piece_mask = mask;
        bus.base_row   = base;
        bus.start      = 1'b1;
        sb_q.push_back(model(mask, base));
    endtask

    // Entered 1 time unit after the start edge (cycle 1 of the scan).
    task automatic collect(input string tag, output exp_t e);
        int   cyc;
        int   step;
        int   row;
        logic seen;
        cyc  = 1;
        seen = 1'b0;
        e    = sb_q[0];
        while (cyc <= 12 && !seen) begin
            if (bus.done) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                chk({tag, " collision"}, bus.collision, e.coll);
                chk({tag, " hit_row"}, bus.hit_row, e.hit);
                chk({tag, " latency"}, cyc, e.lat);
                chk({tag, " addr_done"}, bus.board_rd_addr, 0);
            end else begin
                step = (cyc - 1) / 2;
                row  = int'(e.base) + step;
                chk({tag, " addr"}, bus.board_rd_addr,
                    (step < 4 && row < 20) ? row : 0);
                chk({tag, " busy"}, bus.busy, 1);
                @(posedge clock);
                #1;
                cyc++;
            end
        end
        if (!seen) begin
            chk({tag, " done_timeout"}, 0, 1);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic scan(input string tag, input logic [127:0] mask, input logic [4:0] base);
        exp_t e;
        issue(mask, base);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        collect(tag, e);
        @(posedge clock);
        #1;
        chk({tag, " done_one_cycle"}, bus.done, 0);
        chk({tag, " idle"}, bus.busy, 0);
        chk({tag, " coll_hold"}, bus.collision, e.coll);
        chk({tag, " hit_hold"}, bus.hit_row, e.hit);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   dones;
        bus.start      = 1'b0;
        bus.piece_mask = '0;
        bus.base_row   = 5'd0;
        for (int i = 0; i < 32; i++) board_mem[i] = 32'd0;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        bus.start = 1'b1;
        bus.piece_mask = pm(32'hF, 0, 0, 0);
        @(posedge clock);
        #1;
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst collision", bus.collision, 0);
        chk("rst hit_row", bus.hit_row, 0);
        chk("rst addr", bus.board_rd_addr, 0);
        bus.start = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        scan("empty", pm(32'h0F, 32'h0F, 0, 0), 5'd5);

        board_mem[7] = 32'h0000_0008;
        scan("row7", pm(0, 0, 32'h0C, 0), 5'd5);
        board_mem[7] = 32'd0;

        scan("floor", pm(32'h1, 32'h1, 32'h1, 0), 5'd18);
        scan("base31", '0, 5'd31);
        scan("zero_beyond", pm(32'h1, 0, 0, 0), 5'd19);
        scan("floor_k3", pm(0, 0, 0, 32'h4), 5'd17);

        board_mem[0] = 32'h8000_0000;
        scan("k0", pm(32'h8000_0001, 0, 0, 0), 5'd0);
        board_mem[13] = 32'h0001_0000;
        scan("k3", pm(32'hFFFE_FFFF, 32'hFFFE_FFFF, 32'hFFFE_FFFF, 32'h0001_0000), 5'd10);
        board_mem[13] = 32'd0;

        // start held high; operands change mid-scan
        board_mem[7] = 32'h0000_0008;
        issue(pm(0, 0, 32'h0C, 0), 5'd5);
        @(posedge clock);
        #1;
        issue(pm(32'hFFFF_FFFF, 0, 0, 0), 5'd0);
        collect("held_a", e);
        @(posedge clock);
        #1;
        chk("held idle_busy", bus.busy, 0);
        chk("held idle_done", bus.done, 0);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        collect("held_b", e);
        @(posedge clock);
        #1;
        chk("held_b idle", bus.busy, 0);
        board_mem[7] = 32'd0;

        // reset during CHECK of piece row 1
        issue('0, 5'd2);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("abort addr_row1", bus.board_rd_addr, 3);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        void'(sb_q.pop_front());
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort collision", bus.collision, 0);
        chk("abort hit_row", bus.hit_row, 0);
        chk("abort addr", bus.board_rd_addr, 0);
        dones = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (bus.done) dones++;
        end
        chk("abort no_done", dones, 0);
        board_mem[4] = 32'h0000_0100;
        scan("after_abort", pm(0, 0, 32'h0000_0300, 0), 5'd2);
        board_mem[4] = 32'd0;

        for (int n = 0; n < 8; n++) begin
            for (int r = 0; r < 20; r++) board_mem[r] = $urandom & $urandom & $urandom;
            scan($sformatf("rand%0d", n),
                 pm($urandom & $urandom, $urandom & $urandom,
                    $urandom & $urandom, $urandom & $urandom),
                 5'($urandom_range(0, 31)));
        end

        chk("scoreboard empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
